// File: rtl/uart_pkg.sv
// Shared types for the oversampling UART: parity modes, receiver FSM states
// and the expected-parity helper.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam int MAX_DATA_W = 9;

  // Parity bit a correct transmitter sends; callers zero-extend narrower words.
  function automatic logic parity_calc(input logic [MAX_DATA_W-1:0] data, input parity_e mode);
    logic p;
    p = ^data;
    return (mode == PAR_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud divider: tick is high for one clock every div+1 clocks, combinational from the count.
// clr holds the phase at zero so the first tick lands div+1 clocks after release; no backpressure.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)         cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = !clr && (cnt == div);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver; o_valid rises 1 clk after the stop-bit sample and holds until i_ready.
// A frame completing into full storage is dropped with a 1-cycle o_overrun. UART_RX_FIFO_EN: 4-deep FIFO.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int OS_RATE     = 16,
  parameter int DIV_W       = 16,
  parameter int PARITY      = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_uart_rx,
  input  logic [DIV_W-1:0]  i_baud_div,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_parity_err,
  output logic              o_frame_err,
  output logic              o_overrun,
  output logic              o_busy
);

  localparam int               OS_W     = $clog2(OS_RATE);
  localparam int               BIT_W    = $clog2(DATA_W + 1);
  localparam parity_e          PAR_MODE = parity_e'(PARITY);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OS_RATE - 1);
  localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OS_RATE / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s, rx_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q  <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], i_uart_rx};
      rx_prev <= rx_s;
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  rx_state_e         state_q, state_d;
  logic [OS_W-1:0]   os_q, os_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              perr_q, perr_d;
  logic              commit, tick, tick_clr;

  assign tick_clr = (state_q == ST_IDLE);
  assign o_busy   = (state_q != ST_IDLE);

  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .clr     (tick_clr),
    .div     (i_baud_div),
    .tick    (tick)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      os_q    <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    os_d    = os_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    perr_d  = perr_q;
    commit  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        os_d = '0;
        if (rx_prev && !rx_s) state_d = ST_START;
      end
      ST_START: if (tick) begin
        // Half-bit check rejects glitches shorter than half a bit.
        if (os_q == OS_HALF) begin
          os_d = '0;
          if (rx_s) begin
            state_d = ST_IDLE;
          end else begin
            bit_d   = '0;
            perr_d  = 1'b0;
            state_d = ST_DATA;
          end
        end else begin
          os_d = os_q + 1'b1;
        end
      end
      ST_DATA: if (tick) begin
        if (os_q == OS_LAST) begin
          os_d    = '0;
          shreg_d = {rx_s, shreg_q[DATA_W-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) state_d = (PAR_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
        end else begin
          os_d = os_q + 1'b1;
        end
      end
      ST_PARITY: if (tick) begin
        if (os_q == OS_LAST) begin
          os_d    = '0;
          perr_d  = (rx_s != parity_calc(MAX_DATA_W'(shreg_q), PAR_MODE));
          state_d = ST_STOP;
        end else begin
          os_d = os_q + 1'b1;
        end
      end
      ST_STOP: if (tick) begin
        // Returning to IDLE at the stop centre leaves half a bit to catch the next start edge.
        if (os_q == OS_LAST) begin
          os_d    = '0;
          commit  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          os_d = os_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic [DATA_W+1:0] new_entry;
  assign new_entry = {shreg_q, perr_q, ~rx_s};

`ifdef UART_RX_FIFO_EN
  logic [DATA_W+1:0] mem [4];
  logic [1:0]        wr_ptr, rd_ptr;
  logic [2:0]        count;
  logic              full, pop, push;

  assign full = (count == 3'd4);
  assign pop  = o_valid && i_ready;
  assign push = commit && (!full || pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      o_overrun <= 1'b0;
    end else begin
      o_overrun <= commit && full && !pop;
      if (push) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign {o_data, o_parity_err, o_frame_err} = mem[rd_ptr];
  assign o_valid = (count != 3'd0);
`else
  logic accept;
  assign accept = o_valid && i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data       <= '0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_valid      <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_overrun <= commit && o_valid && !i_ready;
      if (commit && (!o_valid || i_ready)) begin
        {o_data, o_parity_err, o_frame_err} <= new_entry;
        o_valid <= 1'b1;
      end else if (accept) begin
        o_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: line-level frame driver, frame-level expected-word queue,
// random-ready consumer and directed boundary cases.
module tb_uart_rx_os;

  localparam int DW   = 8;
  localparam int OS   = 16;
  localparam int SYNC = 2;
`ifdef UART_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1, rx_p = 1'b1;
  logic [15:0]   baud_div = 16'd3;
  logic          ready = 1'b0, ready_p = 1'b0;
  logic [DW-1:0] o_data, data_p;
  logic          o_valid, valid_p, perr, perr_p, ferr, ferr_p, ovr, ovr_p, busy, busy_p;

  always #5 clk = ~clk;

  uart_rx_os #(.DATA_W(DW), .OS_RATE(OS), .DIV_W(16), .PARITY(0), .SYNC_STAGES(SYNC)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_uart_rx(rx), .i_baud_div(baud_div),
    .o_data(o_data), .o_valid(o_valid), .i_ready(ready),
    .o_parity_err(perr), .o_frame_err(ferr), .o_overrun(ovr), .o_busy(busy)
  );

  uart_rx_os #(.DATA_W(DW), .OS_RATE(OS), .DIV_W(16), .PARITY(2), .SYNC_STAGES(SYNC)) u_dut_par (
    .i_clk(clk), .i_rst_n(rst_n), .i_uart_rx(rx_p), .i_baud_div(baud_div),
    .o_data(data_p), .o_valid(valid_p), .i_ready(ready_p),
    .o_parity_err(perr_p), .o_frame_err(ferr_p), .o_overrun(ovr_p), .o_busy(busy_p)
  );

  int            n_tests = 0, n_fail = 0;
  int            cyc = 0, rise_cyc = -1, edge_cyc = 0;
  int            ovr_cnt = 0, exp_ovr = 0;
  int            rdy_mode = 0;
  logic [DW+1:0] exp_q [$];
  logic          vld_prev = 1'b0;
  logic          hold_pending = 1'b0;
  logic [DW+1:0] hold_val = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer: random ready, checks popped words against the queue and hold stability.
  initial begin
    forever begin
      @(negedge clk);
      if (o_valid && !vld_prev) rise_cyc = cyc;
      vld_prev = o_valid;
      if (ovr) ovr_cnt++;
      if (!rst_n) begin
        hold_pending = 1'b0;
        ready        = 1'b0;
      end else begin
        if (hold_pending) begin
          chk("hold_vld", o_valid, 1);
          chk("hold_dat", {o_data, perr, ferr}, hold_val);
        end
        ready        = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        hold_pending = o_valid && !ready;
        hold_val     = {o_data, perr, ferr};
        if (o_valid && ready) begin
          chk("pop_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) chk("pop_word", {o_data, perr, ferr}, exp_q.pop_front());
        end
      end
    end
  end

  function automatic int bitp();
    return OS * (int'(baud_div) + 1);
  endfunction

  task automatic drive(input bit which, input bit v, input int n);
    if (which) rx_p = v;
    else       rx   = v;
    repeat (n) @(negedge clk);
  endtask

  // Line 0 frames feed the reference queue: stored unless the consumer is stalled and storage is full.
  task automatic send_frame(input bit which, input logic [DW-1:0] d, input bit par_bit,
                            input bit stop_bit, input int gap);
    int bp;
    bp = bitp();
    if (!which) begin
      if (rdy_mode == 0 && exp_q.size() >= CAP) exp_ovr++;
      else exp_q.push_back({d, 1'b0, ~stop_bit});
    end
    edge_cyc = cyc;
    drive(which, 1'b0, bp);
    for (int i = 0; i < DW; i++) drive(which, d[i], bp);
    if (which) drive(which, par_bit, bp);
    drive(which, stop_bit, bp);
    drive(which, 1'b1, gap);
  endtask

  task automatic par_frame(input logic [DW-1:0] d, input bit pb);
    send_frame(1'b1, d, pb, 1'b1, 2);
    chk("par_vld", valid_p, 1);
    chk("par_dat", data_p, d);
    chk("par_err", perr_p, pb != (^d));
    chk("par_ferr", ferr_p, 0);
    ready_p = 1'b1;
    @(negedge clk);
    ready_p = 1'b0;
    chk("par_pop", valid_p, 0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk(tag, exp_q.size(), 0);
    chk({tag, "_vld"}, o_valid, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out", {o_valid, busy, o_data, perr, ferr, ovr}, 0);
    chk("rst_out_par", {valid_p, busy_p, data_p, perr_p, ferr_p, ovr_p}, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    drive(1'b0, 1'b1, 8);

    // Basic 8N1 frame, latency measured from the line edge through the synchroniser.
    baud_div = 16'd3;
    rdy_mode = 0;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b1, bitp());
    chk("t1_lat", rise_cyc, edge_cyc + SYNC + 1 + (OS / 2 + OS * (DW + 1)) * (int'(baud_div) + 1));
    chk("t1_vld", o_valid, 1);
    chk("t1_dat", o_data, 8'hA5);
    chk("t1_flags", {perr, ferr}, 0);
    repeat (20) @(negedge clk);
    chk("t1_hold", o_data, 8'hA5);
    rdy_mode = 1;
    drain("t1_drain");

    // Glitch of 5 ticks is shorter than the half-bit check.
    drive(1'b0, 1'b0, 5 * (int'(baud_div) + 1));
    chk("t2_busy", busy, 1);
    drive(1'b0, 1'b1, bitp());
    chk("t2_idle", busy, 0);
    chk("t2_novld", o_valid, 0);

    par_frame(8'h3C, 1'b1);
    par_frame(8'h3C, 1'b0);
    for (int i = 0; i < 4; i++) par_frame(8'($urandom), 1'($urandom));

    // Framing error, then a long break.
    rdy_mode = 0;
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, bitp());
    chk("t4_ferr", ferr, 1);
    chk("t4_dat", o_data, 8'h55);
    rdy_mode = 1;
    drain("t4_drain");
    exp_q.push_back({8'h00, 1'b0, 1'b1});
    drive(1'b0, 1'b0, 3 * (DW + 2) * bitp());
    drive(1'b0, 1'b1, bitp());
    drain("t4_break");

    // Overrun with the consumer stalled.
    rdy_mode = 0;
    for (int i = 0; i < CAP + 1; i++) send_frame(1'b0, 8'(8'h11 * (i + 1)), 1'b0, 1'b1, 0);
    repeat (4) @(negedge clk);
    chk("t5_ovr", ovr_cnt, exp_ovr);
    chk("t5_ovr_one", exp_ovr, 1);
    chk("t5_head", o_data, 8'h11);
    rdy_mode = 1;
    drain("t5_drain");

    // Reset in the middle of bit 4 with a word held.
    rdy_mode = 0;
    send_frame(1'b0, 8'h5A, 1'b0, 1'b1, 8);
    drive(1'b0, 1'b0, bitp());
    for (int i = 0; i < 4; i++) drive(1'b0, i[0], bitp());
    drive(1'b0, 1'b0, bitp() / 2);
    chk("t6_busy", busy, 1);
    chk("t6_vld_pre", o_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_out", {o_valid, busy, o_data, perr, ferr, ovr}, 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    drive(1'b0, 1'b1, bitp());
    rdy_mode = 1;
    send_frame(1'b0, 8'h81, 1'b0, 1'b1, bitp());
    drain("t6_drain");

    // Random frames over divider settings including the div = 0 maximum rate.
    for (int f = 0; f < 10; f++) begin
      int            sel;
      logic [DW-1:0] d;
      bit            sb;
      sel      = $urandom_range(0, 3);
      baud_div = 16'((1 << sel) - 1);
      d        = 8'($urandom);
      sb       = ($urandom_range(0, 3) != 0);
      send_frame(1'b0, d, 1'b0, sb, sb ? $urandom_range(0, bitp()) : $urandom_range(1, bitp()));
    end
    drain("rand_drain");
    chk("ovr_total", ovr_cnt, exp_ovr);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Parametrised oversampling UART receiver, successor to the 1-clock-per-bit receiver. Synchronises the async RX line and detects the start bit with a mid-bit false-start check. Samples each bit at its centre using a programmable baud divider, then checks optional parity and the stop bit. Delivers each received word on a valid/ready handshake with a one-entry holding register, and flags overrun, framing and parity errors. Sits between the pad and the command parser / FIFO.

Parameters:
DATA_W, 8, data bits per frame, 5..9
OS_RATE, 16, oversample ticks per bit, even, 4..32
DIV_W, 16, width of baud divider input
PARITY, 0, 0 none, 1 odd, 2 even
SYNC_STAGES, 2, input synchroniser depth, 2..3

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_uart_rx  in  1  async serial line, idle high
i_baud_div  in  DIV_W  clocks per oversample tick minus 1; held stable while o_busy is 1
o_data  out  DATA_W  received word, LSB first on the line
o_valid  out  1  o_data is valid
i_ready  in  1  consumer accepts o_data when o_valid and i_ready are both 1
o_parity_err  out  1  parity mismatch for the held word; qualified by o_valid
o_frame_err  out  1  stop bit sampled low for the held word; qualified by o_valid
o_overrun  out  1  one-cycle pulse: a frame completed while the holding register was full; that frame is dropped
o_busy  out  1  FSM is not in IDLE

Behaviour:
- Reset: i_rst_n is asynchronous, active-low; clock i_clk.
- Reset values: all outputs 0; FSM in IDLE; synchroniser flops reset to 1 (idle line).
- Tick generator: counter runs 0..i_baud_div; tick pulses when it wraps. The counter is cleared when the FSM is in IDLE, so phase aligns to the start edge.
- Edge detect: a falling edge on the synchronised line (previous 1, current 0) while in IDLE moves the FSM to START and clears os_cnt.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - START: on tick, os_cnt increments. At os_cnt == OS_RATE/2-1 the line is sampled:
    - 1 → false start, return to IDLE with no output.
    - 0 → os_cnt clears, bit_cnt clears, go to DATA.
  - DATA: os_cnt counts ticks 0..OS_RATE-1. At OS_RATE-1 the line is sampled into a shift register (shift right, MSB in) and bit_cnt increments. After DATA_W bits, go to PARITY if PARITY != 0, otherwise go to STOP.
  - PARITY: one bit period. The sample is XORed with the data. Error if (odd) XOR-all-including-parity == 0, or (even) XOR-all == 1.
  - STOP: sample at the centre of the stop bit. frame_err = ~sample. The word is then committed and the FSM goes to IDLE at that same tick, which allows back-to-back frames with a half-bit margin.
- Commit, holding register empty: o_data, error flags and o_valid are loaded on the cycle after the stop sample. Latency from stop-bit centre to o_valid is 1 clk.
- Commit, holding register full: the register is not touched, o_overrun pulses for 1 cycle and the new frame is lost.
- Commit coinciding with a handshake: if o_valid && i_ready fires in the same cycle as a commit, the new word loads and o_valid stays 1. No overrun is raised.
- Handshake: o_valid stays high until accepted. o_data and the flags are stable while o_valid && !i_ready.
- i_baud_div == 0: a tick fires every clock, giving the maximum rate.
- Reset mid-frame: the partial frame is discarded and the holding register is cleared.
- Line held low (break): the frame completes with frame_err = 1 and data 0. The FSM then waits in IDLE for a falling edge, so a continuous low produces only one frame.

Optional Feature:
UART_RX_FIFO_EN
- Defined: the holding register is replaced by a 4-entry FIFO storing {data, parity_err, frame_err}. o_valid means the FIFO is non-empty. o_overrun pulses only when a commit happens while the FIFO is full and no pop occurs in that cycle. A simultaneous push and pop when full is legal.
- Undefined: the single holding register behaves as described above.

Decomposition:
- Package uart_pkg holds:
  - parity_e enum {PAR_NONE, PAR_ODD, PAR_EVEN}
  - rx_state_e enum of the FSM states
  - function parity_calc(data, mode)
- Sub-module uart_baud_tick contains the divider counter with a clear input and a tick output; it is reusable by the TX side.
- The FIFO is inline, only under the macro.

Test Plan:
1. i_baud_div=3, OS=16, send 0xA5 8N1 → o_valid rises 1 clk after the stop centre, o_data=0xA5, flags 0; the word holds until i_ready.
2. Glitch low for 5 ticks (<8), then high → no o_valid, o_busy returns to 0 and FSM is IDLE.
3. PARITY=2, send 0x3C with parity bit 1 → o_parity_err=1 and o_data=0x3C. The same frame with parity bit 0 → no error.
4. Send 0x55 with stop bit 0 → o_frame_err=1. Hold the line low for 3 frame times → exactly one frame with o_data=0x00 and frame_err=1.
5. i_ready=0, send 0x11 then 0x22 → o_data stays 0x11 and o_overrun pulses once. With UART_RX_FIFO_EN: 5 frames leave 4 entries readable in order and give one overrun on the 5th.
6. Assert reset during bit 4 of a frame → outputs go to 0 at once. A following clean 0x81 frame is received correctly.
